// File: rtl/pipeline_controller_if.sv
// Hazard/miss/exception inputs and pipeline-bank control outputs of the pipeline controller.
// master = controller side, slave = datapath side.
interface pipeline_controller_if #(
  parameter int unsigned STALL_CNT_WIDTH = 16
);
  logic                       imiss_IF;
  logic                       iready;
  logic                       dmiss_MEM;
  logic                       dready;
  logic                       branch_taken_EX;
  logic                       mem_read_EX;
  logic [4:0]                 rt_EX;
  logic [4:0]                 rs_ID;
  logic [4:0]                 rt_ID;
  logic                       uses_rt_ID;
  logic                       exception;

  logic                       load_IF_ID;
  logic                       load_ID_EX;
  logic                       load_EX_MEM;
  logic                       load_MEM_WB;
  logic                       reset_IF_ID;
  logic                       reset_ID_EX;
  logic                       reset_EX_MEM;
  logic                       reset_MEM_WB;
  logic                       pc_write;
  logic                       exc_ack;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles;

  modport master (
    input  imiss_IF, iready, dmiss_MEM, dready, branch_taken_EX, mem_read_EX,
           rt_EX, rs_ID, rt_ID, uses_rt_ID, exception,
    output load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
           reset_IF_ID, reset_ID_EX, reset_EX_MEM, reset_MEM_WB,
           pc_write, exc_ack, stall_cycles
  );

  modport slave (
    output imiss_IF, iready, dmiss_MEM, dready, branch_taken_EX, mem_read_EX,
           rt_EX, rs_ID, rt_ID, uses_rt_ID, exception,
    input  load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
           reset_IF_ID, reset_ID_EX, reset_EX_MEM, reset_MEM_WB,
           pc_write, exc_ack, stall_cycles
  );
endinterface

// File: rtl/pipeline_controller.sv
// Central sequencer for the IF_ID/ID_EX/EX_MEM/MEM_WB banks: hazards, misses, exceptions
// and a saturating stall-cycle counter. Control outputs are combinational from state and inputs.
module pipeline_controller #(
  parameter int unsigned EXC_FLUSH_CYCLES = 2,
  parameter int unsigned STALL_CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_controller_if.master bus
);

  localparam int unsigned CNT_W = (EXC_FLUSH_CYCLES > 1) ? $clog2(EXC_FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ISTALL = 2'd1,
    S_DSTALL = 2'd2,
    S_EXC    = 2'd3
  } state_t;

  // Bank vectors are ordered {IF_ID, ID_EX, EX_MEM, MEM_WB}
  localparam logic [3:0] BANKS_ALL  = 4'b1111;
  localparam logic [3:0] BANKS_NONE = 4'b0000;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           flush_q, flush_d;
  logic                       exc_first_q, exc_first_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic [3:0]                 load_c;
  logic [3:0]                 rst_c;
  logic                       pc_write_c;
  logic                       load_use_c;

  // Load in EX feeding a source register of the instruction in ID
  always_comb begin
    load_use_c = bus.mem_read_EX && (bus.rt_EX != 5'd0) &&
                 ((bus.rt_EX == bus.rs_ID) || (bus.uses_rt_ID && (bus.rt_EX == bus.rt_ID)));
  end

  // Next state and bank control; event cycles already show the target mode's controls
  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    exc_first_d = 1'b0;
    load_c      = BANKS_NONE;
    rst_c       = BANKS_NONE;
    pc_write_c  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.exception) begin
          state_d     = S_EXC;
          flush_d     = CNT_W'(EXC_FLUSH_CYCLES - 1);
          exc_first_d = 1'b1;
          rst_c       = BANKS_ALL;
        end else if (bus.dmiss_MEM) begin
          state_d = S_DSTALL;
          rst_c   = 4'b0001;
        end else if (bus.branch_taken_EX) begin
          load_c     = 4'b0011;
          rst_c      = 4'b1100;
          pc_write_c = 1'b1;
        end else if (load_use_c) begin
          load_c = 4'b0011;
          rst_c  = 4'b0100;
        end else if (bus.imiss_IF) begin
          state_d = S_ISTALL;
          load_c  = 4'b0111;
          rst_c   = 4'b1000;
        end else begin
          load_c     = BANKS_ALL;
          pc_write_c = 1'b1;
        end
      end

      S_ISTALL: begin
        if (bus.exception) begin
          state_d     = S_EXC;
          flush_d     = CNT_W'(EXC_FLUSH_CYCLES - 1);
          exc_first_d = 1'b1;
          rst_c       = BANKS_ALL;
        end else if (bus.dmiss_MEM) begin
          state_d = S_DSTALL;
          rst_c   = 4'b0001;
        end else begin
          load_c = 4'b0111;
          rst_c  = 4'b1000;
          if (bus.iready) begin
            state_d = S_RUN;
          end
        end
      end

      S_DSTALL: begin
        rst_c = 4'b0001;
        // A pending exception waits here until the data miss resolves
        if (bus.dready) begin
          if (bus.exception) begin
            state_d     = S_EXC;
            flush_d     = CNT_W'(EXC_FLUSH_CYCLES - 1);
            exc_first_d = 1'b1;
          end else if (bus.imiss_IF) begin
            state_d = S_ISTALL;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_EXC: begin
        rst_c      = BANKS_ALL;
        pc_write_c = 1'b1;
        if (flush_q == CNT_W'(0)) begin
          state_d = S_RUN;
        end else begin
          flush_d = flush_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset drives the flush pattern immediately, independent of the clock
    if (reset) begin
      load_c     = BANKS_NONE;
      rst_c      = BANKS_ALL;
      pc_write_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      flush_q     <= '0;
      exc_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      exc_first_q <= exc_first_d;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_write_c && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign bus.load_IF_ID   = load_c[3];
  assign bus.load_ID_EX   = load_c[2];
  assign bus.load_EX_MEM  = load_c[1];
  assign bus.load_MEM_WB  = load_c[0];
  assign bus.reset_IF_ID  = rst_c[3];
  assign bus.reset_ID_EX  = rst_c[2];
  assign bus.reset_EX_MEM = rst_c[1];
  assign bus.reset_MEM_WB = rst_c[0];
  assign bus.pc_write     = pc_write_c;
  assign bus.exc_ack      = (state_q == S_EXC) && exc_first_q && !reset;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a 16-bit counter instance plus a 4-bit counter
// instance sharing the same stimulus to exercise saturation.
module tb_pipeline_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipeline_controller_if #(.STALL_CNT_WIDTH(16)) ifm ();
  pipeline_controller_if #(.STALL_CNT_WIDTH(4))  ifs ();

  pipeline_controller #(.EXC_FLUSH_CYCLES(2), .STALL_CNT_WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.master)
  );

  pipeline_controller #(.EXC_FLUSH_CYCLES(2), .STALL_CNT_WIDTH(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs.master)
  );

  assign ifs.imiss_IF        = ifm.imiss_IF;
  assign ifs.iready          = ifm.iready;
  assign ifs.dmiss_MEM       = ifm.dmiss_MEM;
  assign ifs.dready          = ifm.dready;
  assign ifs.branch_taken_EX = ifm.branch_taken_EX;
  assign ifs.mem_read_EX     = ifm.mem_read_EX;
  assign ifs.rt_EX           = ifm.rt_EX;
  assign ifs.rs_ID           = ifm.rs_ID;
  assign ifs.rt_ID           = ifm.rt_ID;
  assign ifs.uses_rt_ID      = ifm.uses_rt_ID;
  assign ifs.exception       = ifm.exception;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] loads();
    return {ifm.load_IF_ID, ifm.load_ID_EX, ifm.load_EX_MEM, ifm.load_MEM_WB};
  endfunction

  function automatic logic [3:0] resets();
    return {ifm.reset_IF_ID, ifm.reset_ID_EX, ifm.reset_EX_MEM, ifm.reset_MEM_WB};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] l, input logic [3:0] r,
                         input logic pc, input logic [15:0] sc);
    chk({tag, ".load"}, 32'(loads()), 32'(l));
    chk({tag, ".reset"}, 32'(resets()), 32'(r));
    chk({tag, ".pc_write"}, 32'(ifm.pc_write), 32'(pc));
    chk({tag, ".stall"}, 32'(ifm.stall_cycles), 32'(sc));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    ifm.imiss_IF = 1'b0; ifm.iready = 1'b0; ifm.dmiss_MEM = 1'b0; ifm.dready = 1'b0;
    ifm.branch_taken_EX = 1'b0; ifm.mem_read_EX = 1'b0; ifm.rt_EX = 5'd0;
    ifm.rs_ID = 5'd0; ifm.rt_ID = 5'd0; ifm.uses_rt_ID = 1'b0; ifm.exception = 1'b0;

    // Reset held for three cycles
    #2;
    chk_ctl("rst_hold", 4'b0000, 4'b1111, 1'b0, 16'd0);
    chk("rst_hold.exc_ack", 32'(ifm.exc_ack), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk_ctl("rst_release", 4'b1111, 4'b0000, 1'b1, 16'd0);

    // Load-use via rs
    tick();
    ifm.mem_read_EX = 1'b1; ifm.rt_EX = 5'd5; ifm.rs_ID = 5'd5;
    #1 chk_ctl("lu_rs", 4'b0011, 4'b0100, 1'b0, 16'd0);
    tick();
    ifm.rt_EX = 5'd0; ifm.rs_ID = 5'd0;
    #1 chk_ctl("lu_r0", 4'b1111, 4'b0000, 1'b1, 16'd1);
    tick();
    ifm.rt_EX = 5'd7; ifm.rs_ID = 5'd1; ifm.rt_ID = 5'd7; ifm.uses_rt_ID = 1'b0;
    #1 chk_ctl("lu_rt_unused", 4'b1111, 4'b0000, 1'b1, 16'd1);
    tick();
    ifm.uses_rt_ID = 1'b1;
    #1 chk_ctl("lu_rt_used", 4'b0011, 4'b0100, 1'b0, 16'd1);

    // Branch overrides load-use and imiss
    tick();
    ifm.branch_taken_EX = 1'b1; ifm.imiss_IF = 1'b1;
    #1 chk_ctl("branch_lu", 4'b0011, 4'b1100, 1'b1, 16'd2);
    tick();
    ifm.branch_taken_EX = 1'b0; ifm.imiss_IF = 1'b0; ifm.mem_read_EX = 1'b0; ifm.uses_rt_ID = 1'b0;
    #1 chk_ctl("after_branch", 4'b1111, 4'b0000, 1'b1, 16'd2);

    // dmiss and imiss together: 4 DSTALL cycles then ISTALL until iready
    tick();
    ifm.dmiss_MEM = 1'b1; ifm.imiss_IF = 1'b1;
    #1 chk_ctl("dmiss_evt", 4'b0000, 4'b0001, 1'b0, 16'd2);
    tick();
    ifm.dmiss_MEM = 1'b0;
    #1 chk_ctl("dstall1", 4'b0000, 4'b0001, 1'b0, 16'd3);
    tick();
    tick();
    tick();
    ifm.dready = 1'b1;
    #1 chk_ctl("dstall4", 4'b0000, 4'b0001, 1'b0, 16'd6);
    tick();
    ifm.dready = 1'b0;
    #1 chk_ctl("istall1", 4'b0111, 4'b1000, 1'b0, 16'd7);
    tick();
    ifm.iready = 1'b1;
    #1 chk_ctl("istall2", 4'b0111, 4'b1000, 1'b0, 16'd8);
    tick();
    ifm.iready = 1'b0; ifm.imiss_IF = 1'b0;
    #1 chk_ctl("run_after_miss", 4'b1111, 4'b0000, 1'b1, 16'd9);

    // Exception held through DSTALL, taken on dready
    ifm.dmiss_MEM = 1'b1;
    tick();
    ifm.dmiss_MEM = 1'b0; ifm.exception = 1'b1;
    #1 chk_ctl("exc_held", 4'b0000, 4'b0001, 1'b0, 16'd10);
    chk("exc_held.ack", 32'(ifm.exc_ack), 32'd0);
    tick();
    ifm.dready = 1'b1;
    #1 chk("exc_dready.ack", 32'(ifm.exc_ack), 32'd0);
    tick();
    ifm.dready = 1'b0;
    #1 chk_ctl("exc1", 4'b0000, 4'b1111, 1'b1, 16'd12);
    chk("exc1.ack", 32'(ifm.exc_ack), 32'd1);
    ifm.exception = 1'b0;
    tick();
    #1 chk_ctl("exc2", 4'b0000, 4'b1111, 1'b1, 16'd12);
    chk("exc2.ack", 32'(ifm.exc_ack), 32'd0);
    tick();
    #1 chk_ctl("exc_done", 4'b1111, 4'b0000, 1'b1, 16'd12);

    // Exception from RUN, then async reset in the middle of EXC
    ifm.exception = 1'b1;
    tick();
    ifm.exception = 1'b0;
    #1 chk("exc_run.ack", 32'(ifm.exc_ack), 32'd1);
    chk("sat_pre", 32'(ifs.stall_cycles), 32'd13);
    #1 reset = 1'b1;
    #1 chk_ctl("async_rst", 4'b0000, 4'b1111, 1'b0, 16'd0);
    chk("async_rst.ack", 32'(ifm.exc_ack), 32'd0);
    chk("async_rst.sat", 32'(ifs.stall_cycles), 32'd0);
    tick();
    reset = 1'b0;
    #1 chk_ctl("rst2_release", 4'b1111, 4'b0000, 1'b1, 16'd0);

    // 20 stalled cycles: 4-bit counter saturates at 15
    ifm.dmiss_MEM = 1'b1;
    tick();
    ifm.dmiss_MEM = 1'b0;
    repeat (14) tick();
    #1 chk("sat15.main", 32'(ifm.stall_cycles), 32'd15);
    chk("sat15.sat", 32'(ifs.stall_cycles), 32'd15);
    repeat (5) tick();
    #1 chk("sat20.main", 32'(ifm.stall_cycles), 32'd20);
    chk("sat20.sat", 32'(ifs.stall_cycles), 32'd15);
    ifm.dready = 1'b1;
    tick();
    ifm.dready = 1'b0;
    #1 chk_ctl("sat_exit", 4'b1111, 4'b0000, 1'b1, 16'd21);
    chk("sat_exit.sat", 32'(ifs.stall_cycles), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
